// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles the requester handshakes, the response buses and the ALU hookup
// for alu_arbiter.
//   req0_* / req1_*  : valid/ready request with operands a, b and op code aluc
//   rsp0_* / rsp1_*  : result pulse, result r, flags {overflow, negative, carry, zero}
//   alu_a/b/aluc     : operands driven to the shared combinational ALU
//   alu_r, alu_*flag : ALU result and flags coming back
// The slave modport is the arbiter's view. The master modport is the
// environment's view: requesters plus ALU.
interface alu_arbiter_if #(
    parameter int W   = 32,
    parameter int OPW = 4
);
    logic           req0_valid;
    logic           req0_ready;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic [OPW-1:0] req0_aluc;
    logic           req1_valid;
    logic           req1_ready;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic [OPW-1:0] req1_aluc;

    logic           rsp0_valid;
    logic [W-1:0]   rsp0_r;
    logic [3:0]     rsp0_flags;
    logic           rsp1_valid;
    logic [W-1:0]   rsp1_r;
    logic [3:0]     rsp1_flags;

    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [OPW-1:0] alu_aluc;
    logic [W-1:0]   alu_r;
    logic           alu_zero;
    logic           alu_carry;
    logic           alu_negative;
    logic           alu_overflow;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_aluc,
        input  req1_valid, req1_a, req1_b, req1_aluc,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_r, rsp0_flags,
        output rsp1_valid, rsp1_r, rsp1_flags,
        output alu_a, alu_b, alu_aluc,
        input  alu_r, alu_zero, alu_carry, alu_negative, alu_overflow
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_aluc,
        output req1_valid, req1_a, req1_b, req1_aluc,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_r, rsp0_flags,
        input  rsp1_valid, rsp1_r, rsp1_flags,
        input  alu_a, alu_b, alu_aluc,
        output alu_r, alu_zero, alu_carry, alu_negative, alu_overflow
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-port round-robin arbiter in front of one shared combinational ALU,
// with a two-stage pipeline.
//   Stage 1 (issue) holds the granted operands and drives the ALU directly.
//   Stage 2 (capture) latches the ALU result and flags, then pulses the
//   response to the port that issued the operation.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   stall  : freezes every register, blocks grants, masks responses
//   prio   : current round-robin priority (0 = port 0 preferred)
//   bus    : alu_arbiter_if.slave (requests, responses, ALU hookup)
module alu_arbiter #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    output logic          prio,
    alu_arbiter_if.slave  bus
);

    logic           run_r;
    logic           prio_r;
    logic           s1_valid_r;
    logic           s1_id_r;
    logic [W-1:0]   s1_a_r;
    logic [W-1:0]   s1_b_r;
    logic [OPW-1:0] s1_aluc_r;
    logic           s2_valid_r;
    logic           s2_id_r;
    logic [W-1:0]   s2_r_r;
    logic [3:0]     s2_flags_r;

    logic           ready0_s;
    logic           ready1_s;
    logic           hs0_s;
    logic           hs1_s;
    logic           hs_s;
    logic [W-1:0]   sel_a_s;
    logic [W-1:0]   sel_b_s;
    logic [OPW-1:0] sel_aluc_s;

    // Grant logic. The preferred port wins a conflict, and a lone requester
    // always wins. run_r keeps both readies low while in reset.
    always_comb begin
        ready0_s = run_r & ~stall & (~prio_r | ~bus.req1_valid);
        ready1_s = run_r & ~stall & (prio_r | ~bus.req0_valid);
        hs0_s    = bus.req0_valid & ready0_s;
        hs1_s    = bus.req1_valid & ready1_s;
        hs_s     = hs0_s | hs1_s;
        if (hs1_s) begin
            sel_a_s    = bus.req1_a;
            sel_b_s    = bus.req1_b;
            sel_aluc_s = bus.req1_aluc;
        end else begin
            sel_a_s    = bus.req0_a;
            sel_b_s    = bus.req0_b;
            sel_aluc_s = bus.req0_aluc;
        end
    end

    // Internal out-of-reset flag that gates the readies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Round-robin priority moves to the port that was not granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (hs_s) begin
            prio_r <= ~hs1_s;
        end
    end

    // Issue stage. The data registers hold when nothing is accepted, which
    // keeps the ALU inputs quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= 1'b0;
            s1_a_r     <= {W{1'b0}};
            s1_b_r     <= {W{1'b0}};
            s1_aluc_r  <= {OPW{1'b0}};
        end else if (!stall) begin
            s1_valid_r <= hs_s;
            if (hs_s) begin
                s1_id_r   <= hs1_s;
                s1_a_r    <= sel_a_s;
                s1_b_r    <= sel_b_s;
                s1_aluc_r <= sel_aluc_s;
            end
        end
    end

    // Capture stage. Latches the ALU output for the operation in stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_id_r    <= 1'b0;
            s2_r_r     <= {W{1'b0}};
            s2_flags_r <= 4'b0000;
        end else if (!stall) begin
            s2_valid_r <= s1_valid_r;
            s2_id_r    <= s1_id_r;
            s2_r_r     <= bus.alu_r;
            s2_flags_r <= {bus.alu_overflow, bus.alu_negative, bus.alu_carry, bus.alu_zero};
        end
    end

    assign prio           = prio_r;
    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.alu_a      = s1_a_r;
    assign bus.alu_b      = s1_b_r;
    assign bus.alu_aluc   = s1_aluc_r;
    // Stall masks the pulse. The held stage-2 entry re-presents it once
    // the stall is released.
    assign bus.rsp0_valid = s2_valid_r & ~s2_id_r & ~stall;
    assign bus.rsp1_valid = s2_valid_r & s2_id_r & ~stall;
    assign bus.rsp0_r     = s2_r_r;
    assign bus.rsp1_r     = s2_r_r;
    assign bus.rsp0_flags = s2_flags_r;
    assign bus.rsp1_flags = s2_flags_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Directed bench for alu_arbiter. A small behavioural ALU sits on the bus:
//   4'b0000 add
//   4'b0001 subtract (carry = borrow)
//   4'b1101 logical shift right (b >> a[4:0])
// Expected values are hand-computed constants.
module tb_alu_arbiter;
    localparam int W   = 32;
    localparam int OPW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic stall;
    logic prio;
    int   n_vec;
    int   n_miss;

    alu_arbiter_if #(.W(W), .OPW(OPW)) bus ();

    alu_arbiter #(.W(W), .OPW(OPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .prio  (prio),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W:0]   sum_m;
    logic [W-1:0] r_m;

    // Behavioural ALU model feeding the arbiter's ALU inputs.
    always_comb begin
        sum_m            = {(W+1){1'b0}};
        r_m              = {W{1'b0}};
        bus.alu_carry    = 1'b0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_aluc)
            4'b0000: begin
                sum_m            = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                r_m              = sum_m[W-1:0];
                bus.alu_carry    = sum_m[W];
                bus.alu_overflow = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (r_m[W-1] != bus.alu_a[W-1]);
            end
            4'b0001: begin
                r_m              = bus.alu_a - bus.alu_b;
                bus.alu_carry    = (bus.alu_a < bus.alu_b);
                bus.alu_overflow = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (r_m[W-1] != bus.alu_a[W-1]);
            end
            4'b1101: r_m = bus.alu_b >> bus.alu_a[4:0];
            default: r_m = {W{1'b0}};
        endcase
        bus.alu_r        = r_m;
        bus.alu_zero     = (r_m == {W{1'b0}});
        bus.alu_negative = r_m[W-1];
    end

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
        bus.req0_valid = v;
        bus.req0_a     = a;
        bus.req0_b     = b;
        bus.req0_aluc  = op;
    endtask

    task automatic set1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
        bus.req1_valid = v;
        bus.req1_a     = a;
        bus.req1_b     = b;
        bus.req1_aluc  = op;
    endtask

    logic [W-1:0] a0_t [4];
    logic [W-1:0] b0_t [4];
    logic [W-1:0] r0_t [3];
    logic [W-1:0] a1_t [3];
    logic [W-1:0] b1_t [3];
    logic [W-1:0] r1_t [3];
    logic [W-1:0] ap_t [3];
    logic [W-1:0] bp_t [3];
    logic [W-1:0] rp_t [3];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        a0_t = '{32'd1, 32'd3, 32'd5, 32'd9};
        b0_t = '{32'd2, 32'd4, 32'd6, 32'd9};
        r0_t = '{32'd3, 32'd7, 32'd11};
        a1_t = '{32'd100, 32'd300, 32'd500};
        b1_t = '{32'd200, 32'd400, 32'd600};
        r1_t = '{32'd300, 32'd700, 32'd1100};
        ap_t = '{32'd7, 32'd9, 32'd11};
        bp_t = '{32'd8, 32'd10, 32'd12};
        rp_t = '{32'd15, 32'd19, 32'd23};

        // Reset state. A pending request must not be seen as ready.
        rst_n = 1'b0;
        stall = 1'b0;
        set0(1'b1, 32'hAAAA_5555, 32'h1234_5678, 4'b0000);
        set1(1'b0, 32'd0, 32'd0, 4'b0000);
        #2;
        check_vec("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
        check_vec("rst_rspv", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
        check_vec("rst_alu_a", {32'd0, bus.alu_a}, 64'd0);
        check_vec("rst_alu_aluc", {60'd0, bus.alu_aluc}, 64'd0);
        check_vec("rst_rsp_r", {bus.rsp1_r, bus.rsp0_r}, 64'd0);
        check_vec("rst_flags", {56'd0, bus.rsp1_flags, bus.rsp0_flags}, 64'd0);
        check_vec("rst_prio", {63'd0, prio}, 64'd0);
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Port 0 alone: srl of all-ones by 0 gives all-ones, negative flag set.
        set0(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1101);
        @(negedge clk);
        check_vec("t1_ready0", {63'd0, bus.req0_ready}, 64'd1);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        @(negedge clk);
        check_vec("t1_alu_a", {32'd0, bus.alu_a}, 64'h8000_0000);
        check_vec("t1_alu_b", {32'd0, bus.alu_b}, 64'hFFFF_FFFF);
        check_vec("t1_alu_aluc", {60'd0, bus.alu_aluc}, 64'hD);
        check_vec("t1_rspv_n1", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
        step();
        @(negedge clk);
        check_vec("t1_rspv_n2", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd1);
        check_vec("t1_rsp0_r", {32'd0, bus.rsp0_r}, 64'hFFFF_FFFF);
        check_vec("t1_rsp0_flags", {60'd0, bus.rsp0_flags}, 64'h4);
        step();
        @(negedge clk);
        check_vec("t1_rspv_n3", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
        check_vec("t1_prio", {63'd0, prio}, 64'd1);

        // Two ops in flight, then an asynchronous reset in mid-cycle.
        step();
        set0(1'b1, 32'h33, 32'h11, 4'b0000);
        set1(1'b1, 32'h55, 32'h11, 4'b0000);
        @(negedge clk);
        check_vec("ar_grant1", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd2);
        step();
        set1(1'b0, 32'd0, 32'd0, 4'b0000);
        @(negedge clk);
        check_vec("ar_grant0", {63'd0, bus.req0_ready}, 64'd1);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        check_vec("ar_pre_rsp1", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("ar_alu", {bus.alu_a, bus.alu_b}, 64'd0);
        check_vec("ar_aluc", {60'd0, bus.alu_aluc}, 64'd0);
        check_vec("ar_rspv", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
        check_vec("ar_rsp_r", {bus.rsp1_r, bus.rsp0_r}, 64'd0);
        check_vec("ar_flags", {56'd0, bus.rsp1_flags, bus.rsp0_flags}, 64'd0);
        check_vec("ar_prio", {63'd0, prio}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check_vec("ar_post_rspv", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
            check_vec("ar_post_prio", {63'd0, prio}, 64'd0);
        end

        // Both ports request continuously: grants alternate 0,1,0,1,0,1.
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 6) begin
                set0(1'b1, a0_t[(i + 1) / 2], b0_t[(i + 1) / 2], 4'b0000);
                set1(1'b1, a1_t[i / 2], b1_t[i / 2], 4'b0000);
            end else begin
                set0(1'b0, 32'd0, 32'd0, 4'b0000);
                set1(1'b0, 32'd0, 32'd0, 4'b0000);
            end
            @(negedge clk);
            if (i < 6) begin
                check_vec("rr_ready", {62'd0, bus.req1_ready, bus.req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
                check_vec("rr_prio", {63'd0, prio}, (i % 2 == 0) ? 64'd0 : 64'd1);
            end
            if (i >= 2) begin
                if ((i - 2) % 2 == 0) begin
                    check_vec("rr_rspv0", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd1);
                    check_vec("rr_rsp0_r", {32'd0, bus.rsp0_r}, {32'd0, r0_t[(i - 2) / 2]});
                end else begin
                    check_vec("rr_rspv1", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd2);
                    check_vec("rr_rsp1_r", {32'd0, bus.rsp1_r}, {32'd0, r1_t[(i - 2) / 2]});
                end
            end else begin
                check_vec("rr_rspv_idle", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
            end
        end

        // Port 1 alone while prio is 0: granted every cycle, prio stays 0.
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 3) begin
                set1(1'b1, ap_t[i], bp_t[i], 4'b0000);
            end else begin
                set1(1'b0, 32'd0, 32'd0, 4'b0000);
            end
            @(negedge clk);
            if (i < 3) begin
                check_vec("p1_ready1", {63'd0, bus.req1_ready}, 64'd1);
            end
            if (i >= 1) begin
                check_vec("p1_prio", {63'd0, prio}, 64'd0);
            end
            if (i >= 2) begin
                check_vec("p1_rspv", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd2);
                check_vec("p1_rsp1_r", {32'd0, bus.rsp1_r}, {32'd0, rp_t[i - 2]});
            end
        end

        // Stall with one op in each stage.
        step();
        set0(1'b1, 32'd20, 32'd22, 4'b0000);
        @(negedge clk);
        check_vec("st_ready0", {63'd0, bus.req0_ready}, 64'd1);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        set1(1'b1, 32'd100, 32'd1, 4'b0001);
        @(negedge clk);
        check_vec("st_ready1", {63'd0, bus.req1_ready}, 64'd1);
        step();
        set1(1'b0, 32'd0, 32'd0, 4'b0000);
        set0(1'b1, 32'd7, 32'd7, 4'b0000);
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_vec("st_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            check_vec("st_rspv", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
            check_vec("st_alu_a", {32'd0, bus.alu_a}, 64'd100);
            check_vec("st_prio", {63'd0, prio}, 64'd0);
            step();
        end
        stall = 1'b0;
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        @(negedge clk);
        check_vec("st_rel_rspv0", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd1);
        check_vec("st_rel_rsp0_r", {32'd0, bus.rsp0_r}, 64'd42);
        step();
        @(negedge clk);
        check_vec("st_rel_rspv1", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd2);
        check_vec("st_rel_rsp1_r", {32'd0, bus.rsp1_r}, 64'd99);
        step();
        @(negedge clk);
        check_vec("st_rel_idle", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);

        // Flag pass-through: 5-5 gives zero, 7FFFFFFF+1 gives overflow and negative.
        step();
        set0(1'b1, 32'd5, 32'd5, 4'b0001);
        @(negedge clk);
        check_vec("fl_ready0", {63'd0, bus.req0_ready}, 64'd1);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        set1(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0000);
        @(negedge clk);
        check_vec("fl_ready1", {63'd0, bus.req1_ready}, 64'd1);
        check_vec("fl_alu_op", {28'd0, bus.alu_aluc, bus.alu_a}, {28'd0, 4'b0001, 32'd5});
        step();
        set1(1'b0, 32'd0, 32'd0, 4'b0000);
        @(negedge clk);
        check_vec("fl_rspv0", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd1);
        check_vec("fl_rsp0_r", {32'd0, bus.rsp0_r}, 64'd0);
        check_vec("fl_rsp0_flags", {60'd0, bus.rsp0_flags}, 64'h1);
        step();
        @(negedge clk);
        check_vec("fl_rspv1", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd2);
        check_vec("fl_rsp1_r", {32'd0, bus.rsp1_r}, 64'h8000_0000);
        check_vec("fl_rsp1_flags", {60'd0, bus.rsp1_flags}, 64'hC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
